// File: rtl/id_pkg.sv
// id_pkg: shared decode/issue types for the ID issue stage.
// Holds RV opcode constants, ALU/branch/memory enums, the issue packet and
// the instruction-buffer entry, plus small decode helpers.
package id_pkg;

  localparam int unsigned ID_XLEN = 32;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
  } branch_type_e;

  typedef enum logic [1:0] { MW_B, MW_H, MW_W, MW_D } mem_width_e;
  typedef enum logic { OP1_RS1, OP1_PC } op1_sel_e;
  typedef enum logic { OP2_RS2, OP2_IMM } op2_sel_e;

  typedef struct packed {
    logic [ID_XLEN-1:0] pc;
    logic [ID_XLEN-1:0] rs1_data;
    logic [ID_XLEN-1:0] rs2_data;
    logic [ID_XLEN-1:0] imm;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    alu_op_e            alu_op;
    logic               alu_word;
    op1_sel_e           op1_sel;
    op2_sel_e           op2_sel;
    logic               mem_read;
    logic               mem_write;
    mem_width_e         mem_width;
    logic               mem_unsigned;
    branch_type_e       branch_type;
    logic               is_jump;
    logic               reg_write;
    logic               illegal;
    logic               pred_taken;
    logic [ID_XLEN-1:0] pred_pc;
  } issue_pkt_t;

  typedef struct packed {
    logic [ID_XLEN-1:0] pc;
    logic [31:0]        inst;
    logic               pred_taken;
    logic [ID_XLEN-1:0] pred_pc;
  } ibuf_entry_t;

  // Sign-extend a 32-bit immediate to the datapath width.
  function automatic logic [ID_XLEN-1:0] sext32(input logic [31:0] v);
    return ID_XLEN'($signed(v));
  endfunction

  // funct3 (+ alternate bit inst[30]) to ALU operation.
  function automatic alu_op_e alu_fn(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/id_ibuf.sv
// id_ibuf: instruction buffer FIFO between fetch and decode.
// Ports: clk, rst_n, push/din (enqueue), pop (dequeue head), clear (empty
// at next edge, overrides push/pop), dout (head entry), full, empty.
// Pointers carry one extra wrap bit to tell full from empty.
module id_ibuf #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         clear,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  head_q, tail_q;
  logic [W-1:0] mem [DEPTH];

  assign empty = (head_q == tail_q);
  assign full  = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
  assign dout  = mem[head_q[AW-1:0]];

  // Pointer update; clear wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (clear) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + (AW+1)'(1);
      if (pop)  head_q <= head_q + (AW+1)'(1);
    end
  end

  // Storage; contents are only observed while non-empty, so no reset.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[tail_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/id_issue_stage.sv
// id_issue_stage: decode/issue stage with instruction buffer, register file
// and per-register scoreboard. Issues to EX only when operands are final.
// Ports: fetch_* (IF side, valid/ready), issue_* (EX side, valid/ready),
// wb_* (writeback), kill_* (squashed writer release), flush,
// redirect_valid/redirect_pc (early branch correction).
// Optional feature macro: ID_EARLY_BRANCH_EN resolves conditional branches
// at issue; when undefined the redirect outputs are tied to zero.
module id_issue_stage
  import id_pkg::*;
#(
  parameter int unsigned XLEN       = ID_XLEN,
  parameter int unsigned NREGS      = 32,
  parameter int unsigned IBUF_DEPTH = 4,
  localparam int unsigned RW        = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_valid,
  output logic            fetch_ready,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [31:0]     fetch_inst,
  input  logic            fetch_pred_taken,
  input  logic [XLEN-1:0] fetch_pred_pc,
  output logic            issue_valid,
  input  logic            issue_ready,
  output issue_pkt_t      issue_pkt,
  input  logic            wb_en,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            kill_en,
  input  logic [RW-1:0]   kill_rd,
  input  logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);
  localparam int unsigned EW = $bits(ibuf_entry_t);

  ibuf_entry_t       push_ent, head;
  logic [EW-1:0]     head_bits;
  logic              full, empty, fire, clear, push;
  issue_pkt_t        d;
  logic              use_rs1, use_rs2, hazard;
  logic [RW-1:0]     rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0]   rs1_data, rs2_data;
  logic [XLEN-1:0]   regs [NREGS];
  logic [NREGS-1:0]  busy, busy_nxt;
  logic [31:0]       inst;

  assign fetch_ready = rst_n && !full;
  assign clear       = flush || redirect_valid;
  assign push        = fetch_valid && fetch_ready && !clear;
  assign push_ent    = '{pc: ID_XLEN'(fetch_pc), inst: fetch_inst,
                         pred_taken: fetch_pred_taken, pred_pc: ID_XLEN'(fetch_pred_pc)};

  id_ibuf #(.W(EW), .DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_ent),
    .pop   (fire),
    .clear (clear),
    .dout  (head_bits),
    .full  (full),
    .empty (empty)
  );

  assign head    = ibuf_entry_t'(head_bits);
  assign inst    = head.inst;
  assign rs1_idx = RW'(inst[19:15]);
  assign rs2_idx = RW'(inst[24:20]);
  assign rd_idx  = RW'(inst[11:7]);

  // Decode of the buffer head (operand data filled in separately).
  always_comb begin
    d            = '0;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    d.pc         = head.pc;
    d.rd         = inst[11:7];
    d.rs1        = inst[19:15];
    d.rs2        = inst[24:20];
    d.pred_taken = head.pred_taken;
    d.pred_pc    = head.pred_pc;
    case (inst[6:0])
      OPC_LUI: begin
        d.reg_write = 1'b1; d.imm = sext32({inst[31:12], 12'b0});
        d.op2_sel = OP2_IMM; d.alu_op = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        d.reg_write = 1'b1; d.imm = sext32({inst[31:12], 12'b0});
        d.op1_sel = OP1_PC; d.op2_sel = OP2_IMM;
      end
      OPC_JAL: begin
        d.reg_write = 1'b1; d.is_jump = 1'b1; d.op1_sel = OP1_PC;
        d.imm = sext32({{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
      end
      OPC_JALR: begin
        d.reg_write = 1'b1; d.is_jump = 1'b1; use_rs1 = 1'b1;
        d.imm = sext32({{20{inst[31]}}, inst[31:20]});
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        d.imm = sext32({{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
        case (inst[14:12])
          3'b000:  d.branch_type = BR_EQ;
          3'b001:  d.branch_type = BR_NE;
          3'b100:  d.branch_type = BR_LT;
          3'b101:  d.branch_type = BR_GE;
          3'b110:  d.branch_type = BR_LTU;
          3'b111:  d.branch_type = BR_GEU;
          default: d.illegal     = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        use_rs1 = 1'b1; d.reg_write = 1'b1; d.mem_read = 1'b1; d.op2_sel = OP2_IMM;
        d.imm = sext32({{20{inst[31]}}, inst[31:20]});
        d.mem_width = mem_width_e'(inst[13:12]); d.mem_unsigned = inst[14];
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; d.mem_write = 1'b1; d.op2_sel = OP2_IMM;
        d.imm = sext32({{20{inst[31]}}, inst[31:25], inst[11:7]});
        d.mem_width = mem_width_e'(inst[13:12]);
      end
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        use_rs1 = 1'b1; d.reg_write = 1'b1; d.op2_sel = OP2_IMM;
        d.imm = sext32({{20{inst[31]}}, inst[31:20]});
        // inst[30] selects SRA only for shifts; for ADDI it is immediate data.
        d.alu_op   = alu_fn(inst[14:12], inst[30] && (inst[14:12] == 3'b101));
        d.alu_word = (inst[6:0] == OPC_OP_IMM_32);
        d.illegal  = d.alu_word && (XLEN != 64);
      end
      OPC_OP, OPC_OP_32: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; d.reg_write = 1'b1;
        d.alu_op   = alu_fn(inst[14:12], inst[30]);
        d.alu_word = (inst[6:0] == OPC_OP_32);
        d.illegal  = d.alu_word && (XLEN != 64);
      end
      OPC_MISC_MEM, OPC_SYSTEM: ;
      default: d.illegal = 1'b1;
    endcase
    // Illegal instructions still flow to EX but touch no registers.
    if (d.illegal) begin
      d.reg_write = 1'b0;
      use_rs1     = 1'b0;
      use_rs2     = 1'b0;
    end
  end

  // Asynchronous register read with same-cycle writeback bypass.
  always_comb begin
    rs1_data = regs[rs1_idx];
    rs2_data = regs[rs2_idx];
    if (wb_en && wb_rd == rs1_idx) rs1_data = wb_data;
    if (wb_en && wb_rd == rs2_idx) rs2_data = wb_data;
    if (rs1_idx == '0) rs1_data = '0;
    if (rs2_idx == '0) rs2_data = '0;
  end

  // Sources may bypass a writeback landing this cycle; WAW may not.
  assign hazard = (use_rs1 && busy[rs1_idx] && !(wb_en && wb_rd == rs1_idx)) ||
                  (use_rs2 && busy[rs2_idx] && !(wb_en && wb_rd == rs2_idx)) ||
                  (d.reg_write && busy[rd_idx]);

  assign issue_valid = !empty && !hazard && !flush;
  assign fire        = issue_valid && issue_ready;

  always_comb begin
    issue_pkt          = d;
    issue_pkt.rs1_data = ID_XLEN'(rs1_data);
    issue_pkt.rs2_data = ID_XLEN'(rs2_data);
    if (empty) issue_pkt = '0;
  end

  // Scoreboard next state: clears first so a same-register set wins.
  always_comb begin
    busy_nxt = busy;
    if (wb_en)   busy_nxt[wb_rd]   = 1'b0;
    if (kill_en) busy_nxt[kill_rd] = 1'b0;
    if (fire && d.reg_write && rd_idx != '0) busy_nxt[rd_idx] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else begin
      busy <= busy_nxt;
      if (wb_en && wb_rd != '0) regs[wb_rd] <= wb_data;
    end
  end

`ifdef ID_EARLY_BRANCH_EN
  logic            br_taken;
  logic [XLEN-1:0] br_target;

  assign br_target = XLEN'(head.pc) + XLEN'(d.imm);

  always_comb begin
    case (d.branch_type)
      BR_EQ:   br_taken = (rs1_data == rs2_data);
      BR_NE:   br_taken = (rs1_data != rs2_data);
      BR_LT:   br_taken = ($signed(rs1_data) <  $signed(rs2_data));
      BR_GE:   br_taken = ($signed(rs1_data) >= $signed(rs2_data));
      BR_LTU:  br_taken = (rs1_data <  rs2_data);
      BR_GEU:  br_taken = (rs1_data >= rs2_data);
      default: br_taken = 1'b0;
    endcase
  end

  // Redirect only when the prediction disagrees with the resolved outcome.
  always_comb begin
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (fire && d.branch_type != BR_NONE && !d.illegal) begin
      if (br_taken && (!head.pred_taken || XLEN'(head.pred_pc) != br_target)) begin
        redirect_valid = 1'b1;
        redirect_pc    = br_target;
      end else if (!br_taken && head.pred_taken) begin
        redirect_valid = 1'b1;
        redirect_pc    = XLEN'(head.pc) + XLEN'(4);
      end
    end
  end
`else
  assign redirect_valid = 1'b0;
  assign redirect_pc    = '0;
`endif

endmodule

// File: doc/id_issue_stage.md
# id_issue_stage

Parametrised decode/issue stage: a fetch-side instruction buffer, an NREGS×XLEN register file, and a per-register scoreboard. Instructions are issued to EX over a valid/ready handshake only when their operands are final. Sits between IF and the ID/EX pipeline register. The scoreboard replaces hazard-unit stalls and distance-based forwarding into ID; conditional branches can optionally resolve at issue.

## Interface
- XLEN, 32: datapath width; 32 or 64.
- NREGS, 32: architectural registers; power of two, ≥2; RW = $clog2(NREGS).
- IBUF_DEPTH, 4: instruction buffer entries; power of two, ≥2.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- fetch_valid  in  1  fetch offers an instruction.
- fetch_ready  out  1  buffer not full.
- fetch_pc  in  XLEN  instruction PC.
- fetch_inst  in  32  instruction word.
- fetch_pred_taken  in  1  predictor said taken.
- fetch_pred_pc  in  XLEN  predicted target.
- issue_valid  out  1  issue_pkt is valid and hazard-free.
- issue_ready  in  1  EX accepts.
- issue_pkt  out  issue_pkt_t  pc, rs1/rs2 data, imm, rd, rs1, rs2, alu_op, src selects, mem fields, branch_type, is_jump, reg_write, illegal, prediction.
- wb_en  in  1  writeback enable.
- wb_rd  in  RW  writeback register.
- wb_data  in  XLEN  writeback data.
- kill_en  in  1  a previously issued, now squashed instruction will not write back.
- kill_rd  in  RW  its rd.
- flush  in  1  discard buffered, un-issued instructions.
- redirect_valid  out  1  early branch mispredict (ID_EARLY_BRANCH_EN only).
- redirect_pc  out  XLEN  corrected fetch PC.

## Operation
- Buffer: FIFO, push on fetch_valid && fetch_ready, pop on issue fire (issue_valid && issue_ready). fetch_ready = !full; a pop in the same cycle does not free a slot for a push.
- Decode: RV32I/RV64I base opcodes, decoded from the buffer head. Immediates are sign-extended to XLEN. Unknown opcode → illegal=1, reg_write=0, still issued.
- Register file reads are asynchronous. Register 0 reads 0 and ignores writes. A read of wb_rd while wb_en is high returns wb_data.
- Scoreboard: busy[NREGS], busy[0] always 0.
  - Set busy[rd] on issue fire with reg_write.
  - Clear busy[wb_rd] on wb_en.
  - Clear busy[kill_rd] on kill_en.
  - If a set and a clear hit the same register in one cycle, set wins.
- Hazard, each checked only for registers the instruction actually uses:
  - source rs1/rs2 busy, unless wb_en && wb_rd==rs this cycle (bypass).
  - rd busy (WAW).
- issue_valid = !empty && !hazard && !flush.
- Flush: buffer emptied at the next edge. Push is ignored in the flush cycle. Scoreboard untouched; squashed in-flight writers are released via kill_en.

## Timing
- Reset (rst_n low): buffer empty, busy all 0, register file all 0.
- Outputs while in reset: fetch_ready=0, issue_valid=0, issue_pkt=0, redirect_valid=0, redirect_pc=0.
- After reset release: fetch_ready=1.
- Latency: a push at edge N is issuable in cycle N+1. Back-to-back independent instructions issue one per cycle.
- RAW on a one-cycle ALU writer: consumer issues in the cycle its producer's wb_en is high.
- issue_pkt is stable while issue_valid && !issue_ready.
- All outputs are combinational from state plus wb/kill/flush inputs. No input→output path through fetch_*.
- Wrap-around: head and tail pointers carry one extra bit. Full when indices match and the extra bits differ.
- Reset asserted mid-operation: everything cleared asynchronously. No partial issue.

## Configuration
- ID_EARLY_BRANCH_EN defined: on issue fire of a branch, compute the condition from the issued operands and target = pc + imm_b. redirect_valid pulses for that cycle in three cases:
  - taken && !pred_taken → redirect_pc = target.
  - taken && pred_pc≠target → redirect_pc = target.
  - !taken && pred_taken → redirect_pc = pc+4.
- On a redirect the buffer is also cleared at that edge, exactly as for flush. The predictor is not updated here.
- ID_EARLY_BRANCH_EN undefined: redirect_valid=0 and redirect_pc=0 constantly. Branches resolve in EX.

## Structure
- Package id_pkg holds:
  - opcode constants, alu_op_e, branch_type_e, mem_width_e;
  - issue_pkt_t, parametrised via XLEN-sized fields using the package-level default XLEN.
- Sub-module id_ibuf: parametrised FIFO holding {pc, inst, pred_taken, pred_pc}.
- Register file and scoreboard are inline.

## Test plan
- Push ADDI x1,x0,5 then ADD x2,x1,x1 with issue_ready=1 → ADDI issues; ADD holds issue_valid=0 until wb_en/wb_rd=1/wb_data=5, then issues in that cycle with rs1=rs2=5.
- Fill IBUF_DEPTH=4 with issue_ready=0 → fetch_ready=0 after the 4th push. One pop → fetch_ready=1 the following cycle. Order preserved across pointer wrap over 10 instructions.
- Issue LW x3, then ADDI x3,x3,1 → WAW/RAW stall. kill_en with kill_rd=3 → busy cleared, ADDI issues next cycle reading the register file value.
- flush while 3 entries are buffered → next cycle empty, issue_valid=0. A push during the flush cycle is dropped.
- ID_EARLY_BRANCH_EN: BEQ x0,x0,+16 at pc 0x100, pred_taken=0 → redirect_valid=1, redirect_pc=0x110 on issue. Same BEQ with pred_pc=0x110 → no redirect.
- Assert rst_n low mid-stall with 2 entries buffered and busy[5]=1 → all outputs 0 immediately. After release, fetch_ready=1 and busy all clear.
